dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe_pkg.sv | 8 +
 rtl/dff_stage.sv | 32 +++
 rtl/dff_pipe.sv | 79 +++++++
 tb/tb_dff_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared defaults and count-width helper for dff_pipe
package dff_pipe_pkg;
    localparam int DFF_PIPE_WIDTH_DEF = 8;
    localparam int DFF_PIPE_DEPTH_DEF = 4;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one elastic pipeline register with valid bit and bubble-collapse handshake
module dff_stage #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_d,
    input  logic             dn_accept,
    output logic             valid,
    output logic [WIDTH-1:0] d,
    output logic             accept
);
    logic advance;
    always_comb begin
        advance = valid && dn_accept;
        accept  = !valid || advance;
    end
    // data holds when the word leaves without a replacement; only valid drops
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= 1'b0;
            d     <= RESET_VAL;
        end else if (accept && up_valid) begin
            valid <= 1'b1;
            d     <= up_d;
        end else if (advance) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage valid/ready register pipe with occupancy count.
// DFF_PIPE_FLUSH_EN adds an i_flush port that empties the pipe (reset wins).
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH_DEF,
    parameter int DEPTH = DFF_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef DFF_PIPE_FLUSH_EN
    input  logic                      i_flush,
`endif
    input  logic [WIDTH-1:0]          i_d,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_q,
    output logic [WIDTH-1:0]          o_qb,
    output logic                      o_valid,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);
    logic clr;
    logic in_fire;
    logic out_fire;
`ifdef DFF_PIPE_FLUSH_EN
    assign clr = reset || i_flush;
`else
    assign clr = reset;
`endif
    // per-stage nets live in the generate scope so the accept chain is not one flat vector
    for (genvar k = 0; k < DEPTH; k++) begin : g
        logic             up_valid;
        logic             dn_accept;
        logic             valid;
        logic             accept;
        logic [WIDTH-1:0] up_d;
        logic [WIDTH-1:0] d;
        if (k == 0) begin : h_up
            assign up_valid = i_valid;
            assign up_d     = i_d;
        end else begin : h_up
            assign up_valid = g[k-1].valid;
            assign up_d     = g[k-1].d;
        end
        if (k == DEPTH - 1) begin : h_dn
            assign dn_accept = i_ready;
        end else begin : h_dn
            assign dn_accept = g[k+1].accept;
        end
        dff_stage #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .clr      (clr),
            .up_valid (up_valid),
            .up_d     (up_d),
            .dn_accept(dn_accept),
            .valid    (valid),
            .d        (d),
            .accept   (accept)
        );
    end
    assign o_ready  = g[0].accept;
    assign o_valid  = g[DEPTH-1].valid;
    assign o_q      = g[DEPTH-1].d;
    assign o_qb     = ~o_q;
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;
    always_ff @(posedge clk) begin
        if (clr)
            o_count <= '0;
        else
            o_count <= (in_fire && !out_fire) ? o_count + 1'b1 :
                       (out_fire && !in_fire) ? o_count - 1'b1 : o_count;
    end
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed and scoreboarded checks of dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0)
module tb_dff_pipe;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_d = 8'h00;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_ready;
    logic [7:0] o_q;
    logic [7:0] o_qb;
    logic       o_valid;
    logic [2:0] o_count;
`ifdef DFF_PIPE_FLUSH_EN
    logic       i_flush = 1'b0;
`endif
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef DFF_PIPE_FLUSH_EN
        .i_flush(i_flush),
`endif
        .i_d    (i_d),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_ready(i_ready),
        .o_q    (o_q),
        .o_qb   (o_qb),
        .o_valid(o_valid),
        .o_count(o_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; i_valid = 1'b1; i_d = 8'h33; i_ready = 1'b0;
        tick; tick;
        #1;
        checks++; if (o_q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", o_q); end
        checks++; if (o_qb !== 8'hFF) begin errors++; $display("FAIL reset_qb got=%h exp=FF", o_qb); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_latency;
        reset = 1'b0; i_ready = 1'b1; i_valid = 1'b1; i_d = 8'hA5;
        for (int e = 1; e <= 4; e++) begin
            tick;
            i_valid = 1'b0;
            #1;
            if (e < 4) begin
                checks++;
                if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_early edge=%0d got=%b exp=0", e, o_valid); end
            end
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", o_valid); end
        checks++; if (o_q !== 8'hA5) begin errors++; $display("FAIL latency_q got=%h exp=A5", o_q); end
        checks++; if (o_qb !== 8'h5A) begin errors++; $display("FAIL latency_qb got=%h exp=5A", o_qb); end
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL latency_count got=%0d exp=1", o_count); end
        tick;
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin errors++; $display("FAIL latency_drain got=%b/%0d exp=0/0", o_valid, o_count); end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        i_ready = 1'b0;
        while (sent < 4 && cyc < 20) begin
            i_valid = 1'b1; i_d = 8'(sent + 1);
            #1;
            if (o_ready) sent++;
            tick; cyc++;
        end
        i_valid = 1'b1; i_d = 8'(sent + 1);
        #1;
        checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL bp_full_count got=%0d exp=4", o_count); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", o_ready); end
        checks++; if (o_q !== 8'h01 || o_valid !== 1'b1) begin errors++; $display("FAIL bp_full_head got=%h/%b exp=01/1", o_q, o_valid); end
        i_ready = 1'b1;
        while (got < 10 && cyc < 100) begin
            i_valid = (sent < 10); i_d = 8'(sent + 1);
            #1;
            if (o_valid) begin
                checks++;
                if (o_q !== 8'(got + 1)) begin errors++; $display("FAIL bp_order got=%h exp=%h", o_q, 8'(got + 1)); end
                got++;
            end
            if (i_valid && o_ready) sent++;
            tick; cyc++;
        end
        i_valid = 1'b0;
        checks++; if (got != 10) begin errors++; $display("FAIL bp_all_out got=%0d exp=10", got); end
    endtask

    task automatic test_back_to_back;
        exp_q.delete();
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1; i_d = 8'h10 + 8'(i);
            exp_q.push_back(i_d);
            tick;
        end
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_d = 8'h20 + 8'(i);
            #1;
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, o_ready); end
            checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL b2b_count cyc=%0d got=%0d exp=4", i, o_count); end
            checks++; if (o_q !== exp_q[0]) begin errors++; $display("FAIL b2b_q cyc=%0d got=%h exp=%h", i, o_q, exp_q[0]); end
            void'(exp_q.pop_front());
            exp_q.push_back(i_d);
            tick;
        end
        i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (o_valid !== 1'b1 || o_q !== exp_q[0]) begin errors++; $display("FAIL b2b_drain got=%h/%b exp=%h/1", o_q, o_valid, exp_q[0]); end
            void'(exp_q.pop_front());
            tick;
        end
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin errors++; $display("FAIL b2b_empty got=%b/%0d exp=0/0", o_valid, o_count); end
    endtask

    task automatic test_random;
        int bad_qb = 0;
        exp_q.delete();
        for (int c = 0; c < 1006; c++) begin
            i_valid = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            i_d = 8'($urandom);
            #1;
            if (o_qb !== ~o_q) bad_qb++;
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious got=%h exp=none", o_q);
                end else begin
                    if (o_q !== exp_q[0]) begin errors++; $display("FAIL rand_order got=%h exp=%h", o_q, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (i_valid && o_ready) exp_q.push_back(i_d);
            tick;
        end
        i_valid = 1'b0;
        checks++; if (bad_qb != 0) begin errors++; $display("FAIL rand_qb got=%0d bad cycles exp=0", bad_qb); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_d = 8'h71 + 8'(i);
            tick;
        end
        i_valid = 1'b0;
        #1;
        checks++; if (o_count !== 3'd3) begin errors++; $display("FAIL mid_fill got=%0d exp=3", o_count); end
`ifdef DFF_PIPE_FLUSH_EN
        i_flush = 1'b1;
`else
        reset = 1'b1;
`endif
        i_valid = 1'b1; i_d = 8'h7F;
        tick;
`ifdef DFF_PIPE_FLUSH_EN
        i_flush = 1'b0;
`else
        reset = 1'b0;
`endif
        i_valid = 1'b0; i_ready = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", o_valid); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", o_count); end
        checks++; if (o_q !== 8'h00 || o_qb !== 8'hFF) begin errors++; $display("FAIL mid_q got=%h/%h exp=00/FF", o_q, o_qb); end
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost cyc=%0d got=%h exp=no word", i, o_q); end
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
